// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter
//   Shares a single fp_adder between NUM_REQ requesters using round-robin
//   arbitration. Only one operation is in flight at a time: the winner's
//   operands are latched, the adder is started, the arbiter waits for the
//   adder's valid, then presents the result to the winner until it accepts.
//
//   Optional feature: define FPA_ARB_TIMEOUT_EN to enable a WAIT-state
//   watchdog (TIMEOUT_CYCLES). When it expires, a zero result with
//   resp_timeout = 1 is returned. Without the macro, WAIT has no limit.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid          per-requester request pending
//   req_op_a/op_b      packed 32-bit operands, requester i at [32*i+:32]
//   req_op_code        packed 3-bit op codes
//   req_mode_fp        per-requester mode select
//   req_round_mode     per-requester rounding select
//   req_ack            one-cycle one-hot accept pulse
//   resp_valid         one-hot response valid
//   resp_ready         per-requester response accept
//   resp_result/flags  shared response buses, qualified by resp_valid
//   resp_timeout       response is a watchdog timeout
//   busy               arbiter not idle
//   fpa_*              adder interface (operands registered, start pulse,
//                      downstream ready, result/flags/valid inputs)

module fp_adder_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [32*NUM_REQ-1:0]  req_op_a,
   input  logic [32*NUM_REQ-1:0]  req_op_b,
   input  logic [3*NUM_REQ-1:0]   req_op_code,
   input  logic [NUM_REQ-1:0]     req_mode_fp,
   input  logic [NUM_REQ-1:0]     req_round_mode,
   output logic [NUM_REQ-1:0]     req_ack,
   output logic [NUM_REQ-1:0]     resp_valid,
   input  logic [NUM_REQ-1:0]     resp_ready,
   output logic [31:0]            resp_result,
   output logic [4:0]             resp_flags,
   output logic                   resp_timeout,
   output logic                   busy,
   output logic [31:0]            fpa_op_a,
   output logic [31:0]            fpa_op_b,
   output logic [2:0]             fpa_op_code,
   output logic                   fpa_mode_fp,
   output logic                   fpa_round_mode,
   output logic                   fpa_start,
   output logic                   fpa_ready_in,
   input  logic [31:0]            fpa_result,
   input  logic [4:0]             fpa_flags,
   input  logic                   fpa_valid_out
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   grant_q, grant_d;
   logic [IdxW-1:0]   last_grant_q, last_grant_d;
   logic [31:0]       op_a_q, op_a_d;
   logic [31:0]       op_b_q, op_b_d;
   logic [2:0]        op_code_q, op_code_d;
   logic              mode_fp_q, mode_fp_d;
   logic              round_mode_q, round_mode_d;
   logic [31:0]       result_q, result_d;
   logic [4:0]        flags_q, flags_d;
   logic              timeout_q, timeout_d;

   logic              pick_found;
   logic [IdxW-1:0]   pick_idx;
   logic              tmo_hit;

   // Round-robin pick: first set bit searching upward from last_grant+1, wrapping.
   always_comb begin
      int unsigned     cand;
      logic [IdxW-1:0] cand_idx;
      cand       = 0;
      cand_idx   = '0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand     = (32'(last_grant_q) + k) % NUM_REQ;
         cand_idx = cand[IdxW-1:0];
         if (!pick_found && req_valid[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

`ifdef FPA_ARB_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

   // Cleared while issuing so the first WAIT cycle sees a count of zero.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == StIssue) begin
         tmo_cnt_d = '0;
      end else if (state_q == StWait) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   assign tmo_hit = (state_q == StWait) && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYCLES;
   assign tmo_hit    = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (pick_found) state_d = StIssue;
         StIssue: state_d = StWait;
         StWait:  if (fpa_valid_out || tmo_hit) state_d = StResp;
         StResp:  if (resp_ready[grant_q]) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      req_ack      = '0;
      resp_valid   = '0;
      fpa_start    = 1'b0;
      fpa_ready_in = 1'b0;
      unique case (state_q)
         StIssue: begin
            req_ack[grant_q] = 1'b1;
            fpa_start        = 1'b1;
         end
         StWait:  fpa_ready_in = 1'b1;
         StResp:  resp_valid[grant_q] = 1'b1;
         default: ;
      endcase
   end

   assign busy = (state_q != StIdle);

   // Datapath next state
   always_comb begin
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_code_d    = op_code_q;
      mode_fp_d    = mode_fp_q;
      round_mode_d = round_mode_q;
      result_d     = result_q;
      flags_d      = flags_q;
      timeout_d    = timeout_q;
      if (state_q == StIdle && pick_found) begin
         grant_d      = pick_idx;
         op_a_d       = req_op_a[32*pick_idx +: 32];
         op_b_d       = req_op_b[32*pick_idx +: 32];
         op_code_d    = req_op_code[3*pick_idx +: 3];
         mode_fp_d    = req_mode_fp[pick_idx];
         round_mode_d = req_round_mode[pick_idx];
      end
      if (state_q == StWait) begin
         // A real result beats a coincident timeout.
         if (fpa_valid_out) begin
            result_d  = fpa_result;
            flags_d   = fpa_flags;
            timeout_d = 1'b0;
         end else if (tmo_hit) begin
            result_d  = '0;
            flags_d   = '0;
            timeout_d = 1'b1;
         end
      end
      if (state_q == StResp && resp_ready[grant_q]) begin
         last_grant_d = grant_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q      <= '0;
         last_grant_q <= IdxW'(NUM_REQ - 1);
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_code_q    <= '0;
         mode_fp_q    <= 1'b0;
         round_mode_q <= 1'b0;
         result_q     <= '0;
         flags_q      <= '0;
         timeout_q    <= 1'b0;
      end else begin
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_code_q    <= op_code_d;
         mode_fp_q    <= mode_fp_d;
         round_mode_q <= round_mode_d;
         result_q     <= result_d;
         flags_q      <= flags_d;
         timeout_q    <= timeout_d;
      end
   end

   assign fpa_op_a       = op_a_q;
   assign fpa_op_b       = op_b_q;
   assign fpa_op_code    = op_code_q;
   assign fpa_mode_fp    = mode_fp_q;
   assign fpa_round_mode = round_mode_q;
   assign resp_result    = result_q;
   assign resp_flags     = flags_q;
   assign resp_timeout   = timeout_q;

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed testbench for fp_adder_arbiter with a small behavioural adder model.
// Build with FPA_ARB_TIMEOUT_EN defined to exercise the watchdog (TIMEOUT_CYCLES = 8).

module tb_fp_adder_arbiter;

`ifdef FPA_ARB_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 64;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    req_valid;
   logic [127:0]  req_op_a;
   logic [127:0]  req_op_b;
   logic [11:0]   req_op_code;
   logic [3:0]    req_mode_fp;
   logic [3:0]    req_round_mode;
   logic [3:0]    req_ack;
   logic [3:0]    resp_valid;
   logic [3:0]    resp_ready;
   logic [31:0]   resp_result;
   logic [4:0]    resp_flags;
   logic          resp_timeout;
   logic          busy;
   logic [31:0]   fpa_op_a;
   logic [31:0]   fpa_op_b;
   logic [2:0]    fpa_op_code;
   logic          fpa_mode_fp;
   logic          fpa_round_mode;
   logic          fpa_start;
   logic          fpa_ready_in;
   logic [31:0]   model_result;
   logic [4:0]    model_flags;
   logic          fpa_valid_out;

   int            checks = 0;
   int            errors = 0;
   int            model_lat = 3;
   logic          model_en = 1'b1;
   int            mcnt;

   always #5 clk = ~clk;

   fp_adder_arbiter #(
      .NUM_REQ        (4),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_op_a       (req_op_a),
      .req_op_b       (req_op_b),
      .req_op_code    (req_op_code),
      .req_mode_fp    (req_mode_fp),
      .req_round_mode (req_round_mode),
      .req_ack        (req_ack),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_result    (resp_result),
      .resp_flags     (resp_flags),
      .resp_timeout   (resp_timeout),
      .busy           (busy),
      .fpa_op_a       (fpa_op_a),
      .fpa_op_b       (fpa_op_b),
      .fpa_op_code    (fpa_op_code),
      .fpa_mode_fp    (fpa_mode_fp),
      .fpa_round_mode (fpa_round_mode),
      .fpa_start      (fpa_start),
      .fpa_ready_in   (fpa_ready_in),
      .fpa_result     (model_result),
      .fpa_flags      (model_flags),
      .fpa_valid_out  (fpa_valid_out)
   );

   // Adder model: valid pulses model_lat cycles after the start pulse.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt          <= 0;
         fpa_valid_out <= 1'b0;
      end else begin
         fpa_valid_out <= 1'b0;
         if (fpa_start) begin
            mcnt <= model_lat;
         end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && model_en) fpa_valid_out <= 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input string tag, input logic [3:0] exp);
      int n = 0;
      while (req_ack == 4'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(req_ack), 64'(exp));
   endtask

   task automatic wait_resp(input string tag, input logic [3:0] exp);
      int n = 0;
      while (resp_valid == 4'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(resp_valid), 64'(exp));
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(busy), 64'(0));
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req_valid  = '0;
      resp_ready = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      req_valid      = '0;
      req_op_a       = '0;
      req_op_b       = '0;
      req_op_code    = '0;
      req_mode_fp    = '0;
      req_round_mode = '0;
      resp_ready     = '0;
      model_result   = '0;
      model_flags    = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ack",     64'(req_ack),      64'(0));
      chk("rst_rvalid",  64'(resp_valid),   64'(0));
      chk("rst_busy",    64'(busy),         64'(0));
      chk("rst_start",   64'(fpa_start),    64'(0));
      chk("rst_readyin", 64'(fpa_ready_in), 64'(0));
      chk("rst_opa",     64'(fpa_op_a),     64'(0));
      chk("rst_result",  64'(resp_result),  64'(0));
      chk("rst_tmo",     64'(resp_timeout), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Single operation 1.0 + 2.0 = 3.0 from requester 0
      req_op_a[31:0] = 32'h3F80_0000;
      req_op_b[31:0] = 32'h4000_0000;
      req_mode_fp    = 4'b0001;
      req_valid      = 4'b0001;
      model_result   = 32'h4040_0000;
      model_flags    = 5'h00;
      model_lat      = 3;
      @(negedge clk);
      chk("t1_ack",    64'(req_ack),     64'(4'b0001));
      chk("t1_start",  64'(fpa_start),   64'(1));
      chk("t1_opa",    64'(fpa_op_a),    64'(32'h3F80_0000));
      chk("t1_opb",    64'(fpa_op_b),    64'(32'h4000_0000));
      chk("t1_modefp", 64'(fpa_mode_fp), 64'(1));
      req_valid = '0;
      @(negedge clk);
      chk("t1_ack_pulse", 64'(req_ack),      64'(0));
      chk("t1_readyin",   64'(fpa_ready_in), 64'(1));
      wait_resp("t1_rvalid", 4'b0001);
      chk("t1_result", 64'(resp_result),  64'(32'h4040_0000));
      chk("t1_flags",  64'(resp_flags),   64'(0));
      chk("t1_tmo",    64'(resp_timeout), 64'(0));
      resp_ready = 4'b0001;
      @(negedge clk);
      chk("t1_idle",   64'(busy),       64'(0));
      chk("t1_rdone",  64'(resp_valid), 64'(0));
      resp_ready = '0;

      // Round-robin with all requesting, ready tied high
      do_reset();
      for (int i = 0; i < 4; i++) req_op_a[32*i +: 32] = 32'hA000_0000 | 32'(i);
      model_lat  = 2;
      resp_ready = 4'b1111;
      req_valid  = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_ack("t2_grant", 4'b0001 << (i % 4));
         chk("t2_opa", 64'(fpa_op_a), 64'(32'hA000_0000 | 32'(i % 4)));
         @(negedge clk);
         chk("t2_pulse", 64'(req_ack), 64'(0));
      end
      req_valid = '0;
      wait_idle("t2_idle");

      // Wrap: last grant 2, then 0101 -> 0 then 2
      req_valid = 4'b0100;
      wait_ack("t3_g2", 4'b0100);
      req_valid = '0;
      wait_idle("t3_idle_a");
      req_valid = 4'b0101;
      wait_ack("t3_wrap0", 4'b0001);
      @(negedge clk);
      wait_ack("t3_then2", 4'b0100);
      req_valid = '0;
      wait_idle("t3_idle_b");

      // Response back-pressure
      resp_ready   = '0;
      model_result = 32'hC0A0_0000;
      model_flags  = 5'h01;
      req_valid    = 4'b1111;
      wait_ack("t4_g3", 4'b1000);
      wait_resp("t4_rvalid", 4'b1000);
      model_lat = 20;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t4_hold", 64'({busy, req_ack, resp_valid, resp_result, resp_flags}),
             64'({1'b1, 4'b0000, 4'b1000, 32'hC0A0_0000, 5'h01}));
      end
      resp_ready = 4'b0111;
      @(negedge clk);
      chk("t4_other_ready", 64'({busy, resp_valid}), 64'({1'b1, 4'b1000}));
      resp_ready = 4'b1000;
      @(negedge clk);
      chk("t4_release", 64'({busy, resp_valid}), 64'(0));
      resp_ready = '0;
      @(negedge clk);
      chk("t4_next", 64'(req_ack), 64'(4'b0001));

      // Asynchronous reset during WAIT
      req_valid = '0;
      @(negedge clk);
      chk("t5_wait", 64'(fpa_ready_in), 64'(1));
      #2 rst_n = 1'b0;
      #1 chk("t5_async", 64'({busy, fpa_ready_in, fpa_start, req_ack, resp_valid, fpa_op_a,
                               resp_result}), 64'(0));
      @(negedge clk);
      model_lat  = 2;
      req_valid  = 4'b1111;
      rst_n      = 1'b1;
      @(negedge clk);
      chk("t5_first", 64'(req_ack), 64'(4'b0001));
      chk("t5_nostale", 64'(resp_valid), 64'(0));
      req_valid  = '0;
      resp_ready = 4'b1111;
      wait_idle("t5_idle");

      // Adder never responds
      model_en  = 1'b0;
      req_valid = 4'b0001;
      wait_ack("t6_ack", 4'b0001);
      req_valid = '0;
`ifdef FPA_ARB_TIMEOUT_EN
      for (int i = 0; i < TMO; i++) begin
         @(negedge clk);
         chk("t6_waiting", 64'({busy, fpa_ready_in, resp_valid}), 64'({2'b11, 4'b0000}));
      end
      @(negedge clk);
      chk("t6_rvalid", 64'(resp_valid),   64'(4'b0001));
      chk("t6_tmo",    64'(resp_timeout), 64'(1));
      chk("t6_result", 64'(resp_result),  64'(0));
      chk("t6_flags",  64'(resp_flags),   64'(0));
`else
      repeat (100) @(negedge clk);
      chk("t6_busy",   64'(busy),       64'(1));
      chk("t6_noresp", 64'(resp_valid), 64'(0));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
